fetch_unit: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register of the five-stage RV32I core. Holds the PC, drives the synchronous instruction ROM, and presents `{pc, pc+4, inst, valid}` to ID. It directly consumes the hazard unit's `keep_pc`, `stall_IF_ID` and `flush_IF_ID`, and the EX-stage redirect `take_branch_NextPC` with its target.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit_if_id_reg.sv | 51 +++++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] RV_NOP  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_STEP = 32'd4;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  // Force word alignment of a redirect address.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Hazard, redirect, ROM and IF/ID output signals of the fetch stage.
interface fetch_unit_if;

  logic        keep_pc;
  logic        stall_IF_ID;
  logic        flush_IF_ID;
  logic        take_branch_NextPC;
  logic [31:0] branch_target_EX;
  logic [31:0] irom_addr;
  logic [31:0] irom_inst;
  logic [31:0] pc_ID;
  logic [31:0] pc4_ID;
  logic [31:0] inst_ID;
  logic        valid_ID;
  logic [31:0] bubble_cnt;

  // Fetch unit side.
  modport master (
    input  keep_pc, stall_IF_ID, flush_IF_ID, take_branch_NextPC, branch_target_EX, irom_inst,
    output irom_addr, pc_ID, pc4_ID, inst_ID, valid_ID, bubble_cnt
  );

  // Core / ROM side.
  modport slave (
    output keep_pc, stall_IF_ID, flush_IF_ID, take_branch_NextPC, branch_target_EX, irom_inst,
    input  irom_addr, pc_ID, pc4_ID, inst_ID, valid_ID, bubble_cnt
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, bubbles carry NOP and the current PC.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = RV_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        fetch_ok_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output if_id_t      id_o,
  output logic        bubble_o
);

  if_id_t id_q, id_d;
  if_id_t bubble_fill;

  // Next-state selection by flush/stall/fetch_ok priority.
  always_comb begin
    bubble_fill = '{pc: pc_i, pc4: pc_i + PC_STEP, inst: NOP_INST, valid: 1'b0};
    id_d        = id_q;
    bubble_o    = 1'b0;
    if (flush_i) begin
      id_d     = bubble_fill;
      bubble_o = 1'b1;
    end else if (stall_i) begin
      id_d = id_q;
    end else if (!fetch_ok_i) begin
      id_d     = bubble_fill;
      bubble_o = 1'b1;
    end else begin
      id_d = '{pc: pc_i, pc4: pc_i + PC_STEP, inst: inst_i, valid: 1'b1};
    end
  end

  // Register with asynchronous reset to an empty bubble at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '{pc: RESET_PC, pc4: RESET_PC + PC_STEP, inst: NOP_INST, valid: 1'b0};
    end else begin
      id_q <= id_d;
    end
  end

  assign id_o = id_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, ROM address generation, IF/ID register, bubble counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = RV_NOP
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  logic [31:0] pc_if_q, pc_if_d;
  logic        fetch_ok_q, fetch_ok_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble;
  if_id_t      id;

  // Next PC: redirect beats hold; hold until the ROM has produced its first word.
  always_comb begin
    pc_if_d    = pc_if_q + PC_STEP;
    fetch_ok_d = 1'b1;
    if (bus.take_branch_NextPC) begin
      pc_if_d = align_pc(bus.branch_target_EX);
    end else if (bus.keep_pc || !fetch_ok_q) begin
      pc_if_d = pc_if_q;
    end
  end

  // Saturating count of bubble loads into ID.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // PC, ROM-valid flag and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if_q      <= RESET_PC;
      fetch_ok_q   <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      pc_if_q      <= pc_if_d;
      fetch_ok_q   <= fetch_ok_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  fetch_unit_if_id_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (bus.flush_IF_ID),
    .stall_i    (bus.stall_IF_ID),
    .fetch_ok_i (fetch_ok_q),
    .pc_i       (pc_if_q),
    .inst_i     (bus.irom_inst),
    .id_o       (id),
    .bubble_o   (bubble)
  );

  // ROM sees next PC so its registered output always matches pc_if_q.
  assign bus.irom_addr  = pc_if_d;
  assign bus.pc_ID      = id.pc;
  assign bus.pc4_ID     = id.pc4;
  assign bus.inst_ID    = id.inst;
  assign bus.valid_ID   = id.valid;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized hazards.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INST (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous ROM whose word at each address is the address itself.
  always @(posedge clk) bus.irom_inst <= bus.irom_addr;

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_started;
  logic [31:0] m_id_pc, m_id_pc4, m_id_inst;
  logic        m_id_valid;
  logic [31:0] m_cnt;

  int n_pass = 0;
  int n_fail = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a;
  endfunction

  function automatic logic [31:0] m_next_pc();
    if (bus.take_branch_NextPC) return {bus.branch_target_EX[31:2], 2'b00};
    if (bus.keep_pc || !m_started) return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic m_reset();
    m_pc = RST_PC; m_started = 1'b0;
    m_id_pc = RST_PC; m_id_pc4 = RST_PC + 32'd4; m_id_inst = NOP; m_id_valid = 1'b0;
    m_cnt = 0;
  endtask

  task automatic m_bubble();
    m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_id_inst = NOP; m_id_valid = 1'b0;
    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  // Apply one clock edge to the model using the inputs held during the cycle.
  task automatic m_edge();
    logic [31:0] npc;
    npc = m_next_pc();
    if (bus.flush_IF_ID) m_bubble();
    else if (bus.stall_IF_ID) begin end
    else if (!m_started) m_bubble();
    else begin
      m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_id_inst = rom(m_pc); m_id_valid = 1'b1;
    end
    m_pc = npc;
    m_started = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".irom_addr"}, bus.irom_addr, m_next_pc());
    chk({tag, ".pc_ID"}, bus.pc_ID, m_id_pc);
    chk({tag, ".pc4_ID"}, bus.pc4_ID, m_id_pc4);
    chk({tag, ".inst_ID"}, bus.inst_ID, m_id_inst);
    chk({tag, ".valid_ID"}, {31'd0, bus.valid_ID}, {31'd0, m_id_valid});
    chk({tag, ".bubble_cnt"}, bus.bubble_cnt, m_cnt);
  endtask

  task automatic set_in(input logic k, input logic s, input logic f, input logic b,
                        input logic [31:0] t);
    bus.keep_pc = k; bus.stall_IF_ID = s; bus.flush_IF_ID = f;
    bus.take_branch_NextPC = b; bus.branch_target_EX = t;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  // Advance with no hazards until the model PC reaches target (bounded).
  task automatic run_to(input logic [31:0] target);
    for (int i = 0; i < 200 && m_pc != target; i++) begin
      chk_all("run");
      tick();
    end
    if (m_pc != target) begin
      n_fail++;
      $error("FAIL run_to observed_pc=%h expected_pc=%h", m_pc, target);
    end
  endtask

  // Reset release: one bubble, then 0, 4, 8 in consecutive cycles.
  task automatic release_seq(input string tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); chk_all(tag);
    chk({tag, ".first_valid"}, {31'd0, bus.valid_ID}, 32'd0);
    chk({tag, ".first_cnt"}, bus.bubble_cnt, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all(tag);
      chk({tag, ".pc_seq"}, bus.pc_ID, 32'(i * 4));
      chk({tag, ".inst_seq"}, bus.inst_ID, 32'(i * 4));
      chk({tag, ".pc4_seq"}, bus.pc4_ID, 32'(i * 4 + 4));
      chk({tag, ".valid_seq"}, {31'd0, bus.valid_ID}, 32'd1);
    end
    chk({tag, ".cnt_after"}, bus.bubble_cnt, 32'd1);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 32'h0);
    rst_n = 1'b0;
    m_reset();
    #12;
    chk_all("reset");
    chk("reset.valid", {31'd0, bus.valid_ID}, 32'd0);
    chk("reset.inst", bus.inst_ID, NOP);
    chk("reset.pc4", bus.pc4_ID, 32'd4);
    chk("reset.irom_addr", bus.irom_addr, RST_PC);
    chk("reset.cnt", bus.bubble_cnt, 32'd0);

    release_seq("boot");

    // Redirect while pc_IF = 0x20.
    run_to(32'h20);
    set_in(0, 0, 1, 1, 32'h0000_0102);
    chk("redir.irom_addr", bus.irom_addr, 32'h100);
    tick();
    set_in(0, 0, 0, 0, 32'h0);
    chk_all("redir1");
    chk("redir.bubble_valid", {31'd0, bus.valid_ID}, 32'd0);
    chk("redir.bubble_inst", bus.inst_ID, NOP);
    tick(); chk_all("redir2");
    chk("redir.target_pc", bus.pc_ID, 32'h100);
    chk("redir.target_valid", {31'd0, bus.valid_ID}, 32'd1);

    // Load-use hold with pc_IF = 0x40.
    set_in(0, 0, 0, 1, 32'h30);
    tick();
    set_in(0, 0, 0, 0, 32'h0);
    run_to(32'h40);
    set_in(1, 1, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      chk("hold.irom_addr", bus.irom_addr, 32'h40);
      tick(); chk_all("hold");
      chk("hold.pc_ID", bus.pc_ID, 32'h3C);
    end
    set_in(0, 0, 0, 0, 32'h0);
    chk("hold.release_addr", bus.irom_addr, 32'h44);
    tick(); chk_all("hold_rel1");
    chk("hold.next_pc", bus.pc_ID, 32'h40);
    chk("hold.next_inst", bus.inst_ID, 32'h40);
    tick(); chk_all("hold_rel2");
    chk("hold.after_pc", bus.pc_ID, 32'h44);

    // Everything at once with a redirect to 0x200.
    set_in(1, 1, 1, 1, 32'h200);
    chk("all.irom_addr", bus.irom_addr, 32'h200);
    tick();
    set_in(0, 0, 0, 0, 32'h0);
    chk_all("all1");
    chk("all.flush_valid", {31'd0, bus.valid_ID}, 32'd0);
    tick(); chk_all("all2");
    chk("all.target_pc", bus.pc_ID, 32'h200);
    chk("all.target_valid", {31'd0, bus.valid_ID}, 32'd1);

    // PC wrap at the top of the address space.
    set_in(0, 0, 0, 1, 32'hFFFF_FFFC);
    tick();
    set_in(0, 0, 0, 0, 32'h0);
    chk("wrap.irom_addr", bus.irom_addr, 32'h0);
    tick(); chk_all("wrap1");
    chk("wrap.pc_ID", bus.pc_ID, 32'hFFFF_FFFC);
    chk("wrap.pc4_ID", bus.pc4_ID, 32'h0);
    tick(); chk_all("wrap2");
    chk("wrap.next_pc", bus.pc_ID, 32'h0);

    // Asynchronous reset in the middle of a load-use hold.
    set_in(1, 1, 0, 0, 32'h0);
    tick(); tick();
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_all("midrst");
    chk("midrst.valid", {31'd0, bus.valid_ID}, 32'd0);
    chk("midrst.cnt", bus.bubble_cnt, 32'd0);
    chk("midrst.pc_ID", bus.pc_ID, RST_PC);
    set_in(0, 0, 0, 0, 32'h0);
    release_seq("reboot");

    // Randomized hazards against the model.
    for (int i = 0; i < 400; i++) begin
      logic k, s, f, b;
      k = ($urandom_range(0, 3) == 0);
      s = k ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 9) == 0);
      set_in(k, s, f, b, $urandom);
      chk_all("rand");
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        m_reset();
        #1;
        chk_all("rand_rst");
        set_in(0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    set_in(0, 0, 0, 0, 32'h0);
    chk_all("final");

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
